// File: rtl/execute_stage.sv
// ============================================================================
//  Module   : execute_stage
//  Purpose  : RV32I execute stage. Forwards operands, runs the ALU, resolves
//             branch/jump redirection combinationally and holds the EX/MEM
//             pipeline register that feeds the memory stage.
//  Ports    :
//    clk, rst                  - clock, synchronous active-high reset
//    RegWriteE, MemWriteE      - write enables from ID/EX
//    JumpE, BranchE            - JAL / BEQ qualifiers
//    ALUSrcE                   - 0: SrcB = forwarded RD2, 1: SrcB = Imm_ExtE
//    ResultSrcE                - writeback select (pass-through)
//    ALU_CtrlE                 - ALU operation select
//    RD1_E, RD2_E              - register operands
//    PCE, Imm_ExtE, PCPlus4E   - PC, immediate, PC+4 of the EX instruction
//    RdE                       - destination register index
//    ForwardAE, ForwardBE      - operand forwarding selects
//    ResultW                   - writeback result for forwarding
//    PCSrcE, PCTargetE         - combinational redirect and target
//    RegWriteM .. PCPlus4M     - registered EX/MEM outputs
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic        JumpE,
  input  logic        BranchE,
  input  logic        ALUSrcE,
  input  logic [1:0]  ResultSrcE,
  input  logic [2:0]  ALU_CtrlE,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] PCE,
  input  logic [31:0] Imm_ExtE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RdE,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ResultW,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic [1:0]  ResultSrcM,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [4:0]  RdM,
  output logic [31:0] PCPlus4M
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] write_data_e;
  logic [31:0] alu_result_e;
  logic        zero_e;

  // Operand forwarding. Select 11 is unused by the hazard unit and falls
  // back to the register-file value.
  always_comb begin
    src_a = RD1_E;
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUResultM;
      default: src_a = RD1_E;
    endcase
  end

  always_comb begin
    write_data_e = RD2_E;
    case (ForwardBE)
      2'b01:   write_data_e = ResultW;
      2'b10:   write_data_e = ALUResultM;
      default: write_data_e = RD2_E;
    endcase
  end

  // Store data is taken before the immediate mux so stores carry rs2.
  assign src_b = ALUSrcE ? Imm_ExtE : write_data_e;

  always_comb begin
    alu_result_e = 32'd0;
    case (ALU_CtrlE)
      ALU_ADD: alu_result_e = src_a + src_b;
      ALU_SUB: alu_result_e = src_a - src_b;
      ALU_AND: alu_result_e = src_a & src_b;
      ALU_OR:  alu_result_e = src_a | src_b;
      ALU_XOR: alu_result_e = src_a ^ src_b;
      ALU_SLT: alu_result_e = {31'd0, ($signed(src_a) < $signed(src_b))};
      ALU_SLL: alu_result_e = src_a << src_b[4:0];
      ALU_SRL: alu_result_e = src_a >> src_b[4:0];
      default: alu_result_e = 32'd0;
    endcase
  end

  assign zero_e    = (alu_result_e == 32'd0);
  assign PCTargetE = PCE + Imm_ExtE;
  assign PCSrcE    = JumpE | (BranchE & zero_e);

  // EX/MEM pipeline register; no stall or flush, loads every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 2'd0;
      ALUResultM <= 32'd0;
      WriteDataM <= 32'd0;
      RdM        <= 5'd0;
      PCPlus4M   <= 32'd0;
    end else begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      ALUResultM <= alu_result_e;
      WriteDataM <= write_data_e;
      RdM        <= RdE;
      PCPlus4M   <= PCPlus4E;
    end
  end

endmodule

`default_nettype wire
